pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage in-order core.
- Drives the IF/ID register controls (id_stall, ifid_flush), plus PC hold, ID/EX bubble insertion and EX hold.
- Handles the following hazards:
  - load-use hazards, with a configurable bubble count;
  - multi-cycle MUL/DIV occupancy of EX;
  - EX-stage control redirects;
  - instruction-memory wait states, including killing an in-flight stale fetch after a redirect.

Parameters:
- LOAD_USE_BUBBLES, 1: bubbles inserted per load-use hazard (1..3); 2 when MEM->EX forwarding is absent.
- MDU_TIMEOUT, 64: maximum MDU_WAIT cycles before mdu_timeout asserts.
- CNT_W, 32: perf counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  ID source reg 1
- id_rs2  in  5  ID source reg 2
- id_uses_rs1  in  1  ID instr reads rs1
- id_uses_rs2  in  1  ID instr reads rs2
- ex_rd  in  5  EX destination reg
- ex_mem_read  in  1  EX instr is a load
- ex_mdu_start  in  1  multi-cycle MUL/DIV entering EX this cycle
- mdu_done  in  1  MDU result valid (1-cycle pulse)
- ex_redirect  in  1  EX resolved taken branch/jump
- imem_ready  in  1  instruction fetch data valid this cycle
- pc_stall  out  1  hold PC
- id_stall  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP (0x00000013) into IF/ID
- idex_flush  out  1  bubble into ID/EX
- ex_stall  out  1  hold ID/EX and EX
- mdu_timeout  out  1  sticky: MDU exceeded MDU_TIMEOUT
- ctrl_state  out  2  current FSM state (debug)

Behaviour:
- States:
  - RUN=0
  - LU_STALL=1
  - MDU_WAIT=2
  - KILL=3
- Reset: while rst is high, state=RUN, bubble counter=0, MDU counter=0, mdu_timeout=0, and all outputs are 0.
- Outputs are combinational from state and current inputs.
- Load-use hazard: lu_hit = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Event priority within a cycle: ex_redirect > ex_mdu_start > lu_hit > !imem_ready.
- RUN:
  - ex_redirect: ifid_flush=1, idex_flush=1, pc_stall=0. If imem_ready=0, go to KILL; otherwise stay in RUN.
  - ex_mdu_start: pc_stall=id_stall=ex_stall=1. Go to MDU_WAIT, MDU counter=0.
  - lu_hit: pc_stall=id_stall=idex_flush=1. If LOAD_USE_BUBBLES>1, go to LU_STALL with counter=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
  - !imem_ready alone: pc_stall=1, ifid_flush=1 (bubble enters ID; the ID instr has already advanced).
- LU_STALL:
  - Each cycle: pc_stall=id_stall=idex_flush=1, decrement counter, return to RUN when the counter reaches 0.
  - ex_redirect in LU_STALL: treated exactly as in RUN; the counter is cleared.
- MDU_WAIT:
  - pc_stall=id_stall=ex_stall=1 every cycle.
  - On mdu_done: release all stalls in that same cycle, go to RUN.
  - MDU counter saturates. When it reaches MDU_TIMEOUT, set mdu_timeout (sticky until rst) and stay in MDU_WAIT.
  - ex_redirect and ex_mdu_start are ignored here; the bench asserts they are never high in this state.
  - mdu_done in the same cycle as entry (0-cycle op) is illegal.
- KILL:
  - Outstanding fetch is from the wrong path. Keep ifid_flush=1 and pc_stall=0 until imem_ready=1, then go to RUN.
  - The fetch returned in that same cycle is discarded (ifid_flush still 1).
  - A new ex_redirect in KILL restarts the kill.
- id_stall and ifid_flush are never both 1; flush wins if logic would produce both.
- Reset mid-operation (any state) returns to RUN immediately. No pending stall survives reset.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined: adds four CNT_W-bit saturating counters, each with an output port (perf_lu, perf_mdu, perf_imem, perf_flush), cleared by rst:
  - perf_lu counts cycles with idex_flush due to load-use;
  - perf_mdu counts MDU_WAIT cycles;
  - perf_imem counts !imem_ready stall cycles;
  - perf_flush counts cycles with ifid_flush from redirect/KILL.
- Undefined: the same ports exist and are tied to 0; no counter logic is present.

Decomposition:
- Shared package core_pipe_pkg contains:
  - state encodings (RUN/LU_STALL/MDU_WAIT/KILL);
  - the NOP constant 32'h00000013;
  - register-index width 5.
- One sub-module: hazard_detect, the combinational lu_hit comparator, reusable by a future forwarding unit.
- The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, LOAD_USE_BUBBLES=1 -> one cycle of pc_stall=id_stall=idex_flush=1, then all 0. Repeat with ex_rd=0 -> no stall.
- LOAD_USE_BUBBLES=2 with the same hazard -> exactly 2 consecutive stall cycles, ctrl_state=1 on the second.
- MDU: pulse ex_mdu_start, mdu_done 4 cycles later -> ex_stall=1 for 4 cycles then 0. With mdu_done withheld past 64 cycles -> mdu_timeout=1 and stays 1 until rst.
- Redirect with imem_ready=0 for 3 cycles -> ifid_flush=1 for 4 cycles (including the stale-return cycle), ctrl_state=3, then RUN.
- Redirect and lu_hit in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0, no subsequent load-use stall.
- Assert rst asynchronously mid-MDU_WAIT -> outputs 0 immediately, ctrl_state=0; after release, the next lu_hit behaves normally.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
//   Definitions shared by the pipeline control blocks: controller state
//   encodings, the canonical NOP instruction word, the register-index width
//   and a small source-operand match helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package core_pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    // addi x0, x0, 0 -- loaded into IF/ID whenever it is flushed
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2,
        KILL     = 2'd3
    } ctrl_state_t;

    // Pipeline control strobes produced each cycle by the sequencer
    typedef struct packed {
        logic pc_stall;
        logic id_stall;
        logic ifid_flush;
        logic idex_flush;
        logic ex_stall;
    } ctrl_out_t;

    // True when a source operand is actually read and names register rd
    function automatic logic src_match(input logic                 uses,
                                       input logic [REG_IDX_W-1:0] rs,
                                       input logic [REG_IDX_W-1:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard sequencer.
//   master : pipeline side (drives ID/EX/fetch status, receives controls)
//   slave  : sequencer side
//   Signals:
//     id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID source operands
//     ex_rd, ex_mem_read                     : EX destination / load flag
//     ex_mdu_start, mdu_done                 : multi-cycle MUL/DIV handshake
//     ex_redirect                            : EX taken branch/jump
//     imem_ready                             : fetch data valid
//     pc_stall, id_stall, ifid_flush,
//     idex_flush, ex_stall                   : pipeline controls
//     mdu_timeout                            : sticky MDU watchdog flag
//     ctrl_state                             : debug view of sequencer state
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    import core_pipe_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_mem_read;
    logic                 ex_mdu_start;
    logic                 mdu_done;
    logic                 ex_redirect;
    logic                 imem_ready;

    logic                 pc_stall;
    logic                 id_stall;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 ex_stall;
    logic                 mdu_timeout;
    logic [1:0]           ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_mdu_start, mdu_done, ex_redirect, imem_ready,
        input  pc_stall, id_stall, ifid_flush, idex_flush, ex_stall,
               mdu_timeout, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_mdu_start, mdu_done, ex_redirect, imem_ready,
        output pc_stall, id_stall, ifid_flush, idex_flush, ex_stall,
               mdu_timeout, ctrl_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use comparator: flags when the instruction in ID reads
//   a register that the load currently in EX will write. x0 never hazards.
//   Ports:
//     rs1, rs2           in  ID source register indices
//     uses_rs1, uses_rs2 in  ID instruction actually reads the operand
//     rd                 in  EX destination register index
//     mem_read           in  EX instruction is a load
//     lu_hit             out load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
    import core_pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 mem_read,
    output logic                 lu_hit
);

    assign lu_hit = mem_read && (rd != '0) &&
                    (src_match(uses_rs1, rs1, rd) || src_match(uses_rs2, rs2, rd));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage in-order core. Resolves
//   load-use hazards, multi-cycle MUL/DIV occupancy of EX, EX redirects and
//   instruction-memory wait states (including killing a stale fetch that is
//   still outstanding after a redirect).
//   Priority within a cycle: redirect > mdu start > load-use > fetch wait.
//
//   Parameters:
//     LOAD_USE_BUBBLES : bubbles per load-use hazard (1..3)
//     MDU_TIMEOUT      : MDU_WAIT cycles before mdu_timeout is raised
//     CNT_W            : performance counter width
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     bus        : pipe_hazard_ctrl_if.slave (hazard inputs, control outputs)
//     perf_lu    : cycles bubbled for load-use
//     perf_mdu   : cycles spent in MDU_WAIT
//     perf_imem  : cycles stalled on fetch wait
//     perf_flush : cycles flushing IF/ID for redirect / stale fetch
//   Build option:
//     PIPE_HAZARD_CTRL_PERF_EN defined   -> saturating perf counters present
//     PIPE_HAZARD_CTRL_PERF_EN undefined -> perf ports tied to zero
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import core_pipe_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned MDU_TIMEOUT      = 64,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]     perf_lu,
    output logic [CNT_W-1:0]     perf_mdu,
    output logic [CNT_W-1:0]     perf_imem,
    output logic [CNT_W-1:0]     perf_flush
);

    localparam int unsigned          MDU_CNT_W  = $clog2(MDU_TIMEOUT + 1);
    localparam logic [MDU_CNT_W-1:0] MDU_MAX    = MDU_CNT_W'(MDU_TIMEOUT);
    localparam logic [MDU_CNT_W-1:0] MDU_LAST   = MDU_CNT_W'(MDU_TIMEOUT - 1);
    localparam logic [MDU_CNT_W-1:0] MDU_ONE    = MDU_CNT_W'(1);
    localparam logic [1:0]           BUB_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

    ctrl_state_t          state, state_next;
    logic [1:0]           bub_cnt, bub_next;
    logic [MDU_CNT_W-1:0] mdu_cnt, mdu_next;
    logic                 tmo_q, tmo_next;
    logic                 lu_hit;
    ctrl_out_t            ctl;

    hazard_detect u_hazard_detect (
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .uses_rs1 (bus.id_uses_rs1),
        .uses_rs2 (bus.id_uses_rs2),
        .rd       (bus.ex_rd),
        .mem_read (bus.ex_mem_read),
        .lu_hit   (lu_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= '0;
            mdu_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_next;
            bub_cnt <= bub_next;
            mdu_cnt <= mdu_next;
            tmo_q   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state;
        bub_next   = bub_cnt;
        mdu_next   = mdu_cnt;
        tmo_next   = tmo_q;
        ctl        = '0;

        unique case (state)
            // LU_STALL shares RUN's redirect handling; otherwise it only
            // counts down the remaining bubbles.
            RUN, LU_STALL: begin
                if (bus.ex_redirect) begin
                    ctl.ifid_flush = 1'b1;
                    ctl.idex_flush = 1'b1;
                    bub_next       = '0;
                    // Fetch still outstanding means it carries the old path
                    state_next     = bus.imem_ready ? RUN : KILL;
                end else if (state == LU_STALL) begin
                    ctl.pc_stall   = 1'b1;
                    ctl.id_stall   = 1'b1;
                    ctl.idex_flush = 1'b1;
                    bub_next       = bub_cnt - 2'd1;
                    if (bub_cnt <= 2'd1) begin
                        state_next = RUN;
                    end
                end else if (bus.ex_mdu_start) begin
                    ctl.pc_stall = 1'b1;
                    ctl.id_stall = 1'b1;
                    ctl.ex_stall = 1'b1;
                    mdu_next     = '0;
                    state_next   = MDU_WAIT;
                end else if (lu_hit) begin
                    ctl.pc_stall   = 1'b1;
                    ctl.id_stall   = 1'b1;
                    ctl.idex_flush = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        bub_next   = BUB_RELOAD;
                        state_next = LU_STALL;
                    end
                end else if (!bus.imem_ready) begin
                    // The ID instruction has already advanced; feed ID a NOP
                    ctl.pc_stall   = 1'b1;
                    ctl.ifid_flush = 1'b1;
                end
            end

            MDU_WAIT: begin
                if (bus.mdu_done) begin
                    // Result is available this cycle, so stalls drop now
                    state_next = RUN;
                end else begin
                    ctl.pc_stall = 1'b1;
                    ctl.id_stall = 1'b1;
                    ctl.ex_stall = 1'b1;
                    if (mdu_cnt != MDU_MAX) begin
                        mdu_next = mdu_cnt + MDU_ONE;
                    end
                    if (mdu_cnt >= MDU_LAST) begin
                        tmo_next = 1'b1;
                    end
                end
            end

            KILL: begin
                // The word returned with imem_ready is stale and is dropped too
                ctl.ifid_flush = 1'b1;
                if (bus.ex_redirect) begin
                    ctl.idex_flush = 1'b1;
                    state_next     = bus.imem_ready ? RUN : KILL;
                end else if (bus.imem_ready) begin
                    state_next = RUN;
                end
            end

            default: state_next = RUN;
        endcase

        if (ctl.ifid_flush) begin
            ctl.id_stall = 1'b0;
        end

        // Outputs are combinational on inputs, so hold them quiet in reset
        if (rst) begin
            ctl = '0;
        end
    end

    assign bus.pc_stall    = ctl.pc_stall;
    assign bus.id_stall    = ctl.id_stall;
    assign bus.ifid_flush  = ctl.ifid_flush;
    assign bus.idex_flush  = ctl.idex_flush;
    assign bus.ex_stall    = ctl.ex_stall;
    assign bus.mdu_timeout = tmo_q;
    assign bus.ctrl_state  = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic ev_lu, ev_mdu, ev_imem, ev_flush;

    // A bubble into ID/EX without an IF/ID flush only arises from load-use;
    // an IF/ID flush without an ID/EX bubble in RUN only from a fetch wait.
    assign ev_lu    = ctl.idex_flush && !ctl.ifid_flush;
    assign ev_mdu   = (state == MDU_WAIT) && !rst;
    assign ev_imem  = (state == RUN) && ctl.ifid_flush && !ctl.idex_flush;
    assign ev_flush = ctl.ifid_flush && !ev_imem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu    <= '0;
            perf_mdu   <= '0;
            perf_imem  <= '0;
            perf_flush <= '0;
        end else begin
            if (ev_lu && perf_lu != '1)       perf_lu    <= perf_lu + CNT_ONE;
            if (ev_mdu && perf_mdu != '1)     perf_mdu   <= perf_mdu + CNT_ONE;
            if (ev_imem && perf_imem != '1)   perf_imem  <= perf_imem + CNT_ONE;
            if (ev_flush && perf_flush != '1) perf_flush <= perf_flush + CNT_ONE;
        end
    end
`else
    assign perf_lu    = '0;
    assign perf_mdu   = '0;
    assign perf_imem  = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two instances (1 and 2 load-use bubbles) share one set of inputs.
//   Single-cycle priority table, directed multi-cycle sequences, then random
//   traffic compared against an event-level reference model.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import core_pipe_pkg::*;

    localparam logic [4:0] PC = 5'b10000;
    localparam logic [4:0] ID = 5'b01000;
    localparam logic [4:0] IF = 5'b00100;
    localparam logic [4:0] IX = 5'b00010;
    localparam logic [4:0] EX = 5'b00001;
    localparam logic [4:0] LU = PC | ID | IX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mdu_start;
    logic mdu_done, ex_redirect, imem_ready;

    pipe_hazard_ctrl_if bus1 ();
    pipe_hazard_ctrl_if bus2 ();

    assign bus1.id_rs1 = id_rs1;             assign bus2.id_rs1 = id_rs1;
    assign bus1.id_rs2 = id_rs2;             assign bus2.id_rs2 = id_rs2;
    assign bus1.id_uses_rs1 = id_uses_rs1;   assign bus2.id_uses_rs1 = id_uses_rs1;
    assign bus1.id_uses_rs2 = id_uses_rs2;   assign bus2.id_uses_rs2 = id_uses_rs2;
    assign bus1.ex_rd = ex_rd;               assign bus2.ex_rd = ex_rd;
    assign bus1.ex_mem_read = ex_mem_read;   assign bus2.ex_mem_read = ex_mem_read;
    assign bus1.ex_mdu_start = ex_mdu_start; assign bus2.ex_mdu_start = ex_mdu_start;
    assign bus1.mdu_done = mdu_done;         assign bus2.mdu_done = mdu_done;
    assign bus1.ex_redirect = ex_redirect;   assign bus2.ex_redirect = ex_redirect;
    assign bus1.imem_ready = imem_ready;     assign bus2.imem_ready = imem_ready;

    logic [31:0] p1_lu, p1_mdu, p1_imem, p1_flush;
    logic [31:0] p2_lu, p2_mdu, p2_imem, p2_flush;

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MDU_TIMEOUT(64), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .perf_lu(p1_lu), .perf_mdu(p1_mdu), .perf_imem(p1_imem), .perf_flush(p1_flush)
    );
    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(2), .MDU_TIMEOUT(64), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .perf_lu(p2_lu), .perf_mdu(p2_mdu), .perf_imem(p2_imem), .perf_flush(p2_flush)
    );

    logic [4:0] o1, o2;
    assign o1 = {bus1.pc_stall, bus1.id_stall, bus1.ifid_flush, bus1.idex_flush, bus1.ex_stall};
    assign o2 = {bus2.pc_stall, bus2.id_stall, bus2.ifid_flush, bus2.idex_flush, bus2.ex_stall};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    int bub[2] = '{1, 2};
    int lu_left[2];   // extra stall cycles still owed after the first bubble
    bit in_mdu[2];
    int mdu_age[2];   // MDU_WAIT cycles elapsed without a result
    bit killing[2];   // a wrong-path fetch is still outstanding
    bit tmo[2];

    function automatic bit m_hit();
        return ex_mem_read && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [4:0] m_out(int k);
        if (in_mdu[k])       return mdu_done ? 5'b0 : (PC | ID | EX);
        if (killing[k])      return ex_redirect ? (IF | IX) : IF;
        if (ex_redirect)     return IF | IX;
        if (lu_left[k] > 0)  return LU;
        if (ex_mdu_start)    return PC | ID | EX;
        if (m_hit())         return LU;
        if (!imem_ready)     return PC | IF;
        return 5'b0;
    endfunction

    function automatic logic [1:0] m_state(int k);
        if (killing[k])     return 2'd3;
        if (in_mdu[k])      return 2'd2;
        if (lu_left[k] > 0) return 2'd1;
        return 2'd0;
    endfunction

    task automatic m_step(int k);
        if (in_mdu[k]) begin
            if (mdu_done) in_mdu[k] = 0;
            else begin
                mdu_age[k]++;
                if (mdu_age[k] >= 64) tmo[k] = 1;
            end
        end else if (killing[k]) begin
            if (ex_redirect) killing[k] = !imem_ready;
            else if (imem_ready) killing[k] = 0;
        end else if (ex_redirect) begin
            lu_left[k] = 0;
            killing[k] = !imem_ready;
        end else if (lu_left[k] > 0) begin
            lu_left[k]--;
        end else if (ex_mdu_start) begin
            in_mdu[k]  = 1;
            mdu_age[k] = 0;
        end else if (m_hit()) begin
            lu_left[k] = bub[k] - 1;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            lu_left[k] = 0; in_mdu[k] = 0; mdu_age[k] = 0; killing[k] = 0; tmo[k] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        ex_mdu_start = 0; mdu_done = 0; ex_redirect = 0; imem_ready = 1;
    endtask

    task automatic set_hazard();
        set_idle();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with active inputs applied to show outputs are held quiet
    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        imem_ready = 0; ex_redirect = 1;
        #1;
        chk("reset outs dut1", 32'(o1), 32'h0);
        chk("reset outs dut2", 32'(o2), 32'h0);
        chk("reset state", 32'(bus1.ctrl_state), 32'h0);
        chk("reset timeout", 32'(bus1.mdu_timeout), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, mr, ms, rdir, im;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            rs1    rs2    rd     u1    u2    mr    ms    rdir  im    exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, LU};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0};
        vecs[3]  = '{5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LU};
        vecs[4]  = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b0};
        vecs[5]  = '{5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PC | IF};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, PC | ID | EX};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, IF | IX};
        vecs[9]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, IF | IX};
        vecs[10] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, PC | ID | EX};
        vecs[11] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, IF | IX};

        set_idle();
        rst = 1'b0;
        #1;

        // ---- single-cycle priority table from RUN ----
        for (int i = 0; i < 13; i++) begin
            do_reset();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_mem_read = vecs[i].mr; ex_mdu_start = vecs[i].ms;
            ex_redirect = vecs[i].rdir; imem_ready = vecs[i].im;
            @(negedge clk);
            chk($sformatf("vec%0d dut1", i), 32'(o1), 32'(vecs[i].exp));
            chk($sformatf("vec%0d dut2", i), 32'(o2), 32'(vecs[i].exp));
        end

        // ---- load-use: 1 bubble on dut1, 2 bubbles on dut2 ----
        do_reset();
        set_hazard();
        @(negedge clk);
        chk("lu c0 dut1", 32'(o1), 32'(LU));
        chk("lu c0 dut2", 32'(o2), 32'(LU));
        tick();
        set_idle();
        @(negedge clk);
        chk("lu c1 dut1", 32'(o1), 32'h0);
        chk("lu c1 dut2", 32'(o2), 32'(LU));
        chk("lu c1 state2", 32'(bus2.ctrl_state), 32'd1);
        tick();
        @(negedge clk);
        chk("lu c2 dut2", 32'(o2), 32'h0);
        chk("lu c2 state2", 32'(bus2.ctrl_state), 32'd0);

        // ---- MDU with result 4 cycles after start ----
        do_reset();
        ex_mdu_start = 1;
        @(negedge clk);
        chk("mdu start", 32'(o1), 32'(PC | ID | EX));
        tick();
        ex_mdu_start = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mdu wait%0d", i), 32'(o1), 32'(PC | ID | EX));
            chk($sformatf("mdu state%0d", i), 32'(bus1.ctrl_state), 32'd2);
            tick();
        end
        mdu_done = 1;
        @(negedge clk);
        chk("mdu done release", 32'(o1), 32'h0);
        tick();
        mdu_done = 0;
        @(negedge clk);
        chk("mdu after state", 32'(bus1.ctrl_state), 32'd0);

        // ---- redirect with fetch outstanding for 3 cycles ----
        do_reset();
        ex_redirect = 1; imem_ready = 0;
        @(negedge clk);
        chk("kill c0", 32'(o1), 32'(IF | IX));
        tick();
        ex_redirect = 0;
        for (int i = 1; i < 4; i++) begin
            imem_ready = (i == 3);
            @(negedge clk);
            chk($sformatf("kill c%0d", i), 32'(o1), 32'(IF));
            chk($sformatf("kill st%0d", i), 32'(bus1.ctrl_state), 32'd3);
            tick();
        end
        @(negedge clk);
        chk("kill done", 32'(o1), 32'h0);
        chk("kill done st", 32'(bus1.ctrl_state), 32'd0);

        // ---- redirect and load-use together ----
        do_reset();
        set_hazard();
        ex_redirect = 1;
        @(negedge clk);
        chk("redir+lu dut2", 32'(o2), 32'(IF | IX));
        tick();
        set_idle();
        @(negedge clk);
        chk("redir+lu after", 32'(o2), 32'h0);
        chk("redir+lu st", 32'(bus2.ctrl_state), 32'd0);

        // ---- asynchronous reset in MDU_WAIT ----
        do_reset();
        ex_mdu_start = 1;
        tick();
        ex_mdu_start = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst outs", 32'(o1), 32'h0);
        chk("async rst st", 32'(bus1.ctrl_state), 32'd0);
        tick();
        rst = 1'b0;
        m_reset();
        set_hazard();
        @(negedge clk);
        chk("post rst lu", 32'(o1), 32'(LU));
        tick();
        set_idle();
        @(negedge clk);
        chk("post rst lu end", 32'(o1), 32'h0);

        // ---- MDU timeout ----
        do_reset();
        ex_mdu_start = 1;
        tick();
        ex_mdu_start = 0;
        repeat (63) tick();
        @(negedge clk);
        chk("tmo before", 32'(bus1.mdu_timeout), 32'h0);
        chk("tmo state", 32'(bus1.ctrl_state), 32'd2);
        tick();
        @(negedge clk);
        chk("tmo set", 32'(bus1.mdu_timeout), 32'h1);
        tick();
        mdu_done = 1;
        tick();
        mdu_done = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("tmo sticky", 32'(bus1.mdu_timeout), 32'h1);
        chk("tmo sticky st", 32'(bus1.ctrl_state), 32'd0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf mdu counted", 32'(p1_mdu != 0), 32'h1);
`else
        chk("perf tied", p1_lu | p1_mdu | p1_imem | p1_flush | p2_lu | p2_mdu | p2_imem | p2_flush, 32'h0);
`endif

        // ---- random traffic against the model ----
        do_reset();
        chk("tmo cleared", 32'(bus1.mdu_timeout), 32'h0);
        for (int n = 0; n < 3000; n++) begin
            automatic bit both_run = !in_mdu[0] && !killing[0] && lu_left[0] == 0 &&
                                     !in_mdu[1] && !killing[1] && lu_left[1] == 0;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read  = ($urandom_range(0, 9) < 4);
            imem_ready   = ($urandom_range(0, 3) != 0);
            ex_redirect  = !in_mdu[0] && ($urandom_range(0, 9) == 0);
            ex_mdu_start = both_run && ($urandom_range(0, 11) == 0);
            mdu_done     = in_mdu[0] && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk($sformatf("rand%0d dut1 out", n), 32'(o1), 32'(m_out(0)));
            chk($sformatf("rand%0d dut2 out", n), 32'(o2), 32'(m_out(1)));
            chk($sformatf("rand%0d dut1 st", n), 32'(bus1.ctrl_state), 32'(m_state(0)));
            chk($sformatf("rand%0d dut2 st", n), 32'(bus2.ctrl_state), 32'(m_state(1)));
            chk($sformatf("rand%0d dut1 tmo", n), 32'(bus1.mdu_timeout), 32'(tmo[0]));
            @(posedge clk);
            m_step(0);
            m_step(1);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
